// File: rtl/lockin_pkg.sv
// ============================================================================
// Module      : lockin_pkg
// Description : Shared definitions for the lock-in polar converter. Holds the
//               FSM state encoding, the CORDIC gain-compensation constant K,
//               the maximum supported iteration count and the arctangent
//               table function. The COMP state is present only when
//               LOCKIN_POLAR_GAINCOMP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lockin_pkg;

    // Largest supported number of CORDIC micro-rotations
    localparam int C_ITER_MAX = 30;

    // 1/An for the CORDIC gain, 0.607253 in Q0.32
    localparam logic [31:0] C_GAIN_K = 32'h9B74EDA8;

`ifdef LOCKIN_POLAR_GAINCOMP_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_ROT  = 2'd2,
        S_COMP = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_ROT  = 2'd2
    } state_t;
`endif

    // round(atan(2^-i) / pi * 2^31): the angle table at 32-bit scale,
    // where 2^31 represents pi. Narrower or wider datapaths rescale it.
    function automatic logic [31:0] cordic_atan(input int i);
        logic [31:0] v;
        case (i)
            0:       v = 32'h20000000;
            1:       v = 32'h12E4051E;
            2:       v = 32'h09FB385B;
            3:       v = 32'h051111D4;
            4:       v = 32'h028B0D43;
            5:       v = 32'h0145D7E1;
            6:       v = 32'h00A2F61E;
            7:       v = 32'h00517C55;
            8:       v = 32'h0028BE53;
            9:       v = 32'h00145F2F;
            10:      v = 32'h000A2F98;
            11:      v = 32'h000517CC;
            12:      v = 32'h00028BE6;
            13:      v = 32'h000145F3;
            14:      v = 32'h0000A2FA;
            15:      v = 32'h0000517D;
            16:      v = 32'h000028BE;
            17:      v = 32'h0000145F;
            18:      v = 32'h00000A30;
            19:      v = 32'h00000518;
            20:      v = 32'h0000028C;
            21:      v = 32'h00000146;
            22:      v = 32'h000000A3;
            23:      v = 32'h00000051;
            24:      v = 32'h00000029;
            25:      v = 32'h00000014;
            26:      v = 32'h0000000A;
            27:      v = 32'h00000005;
            28:      v = 32'h00000003;
            29:      v = 32'h00000001;
            30:      v = 32'h00000001;
            default: v = 32'h00000000;
        endcase
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lockin_polar_if.sv
// ============================================================================
// Module      : lockin_polar_if
// Description : Sample/result bundle between the CIC outputs, the polar
//               converter and the readout logic.
//               master : drives in_valid/x_in/y_in, observes results
//               slave  : the converter (busy, overrun, out_valid, mag, phase)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lockin_polar_if #(
    parameter int W = 32
);
    logic                in_valid;
    logic signed [W-1:0] x_in;
    logic signed [W-1:0] y_in;
    logic                busy;
    logic                overrun;
    logic                out_valid;
    logic        [W-1:0] mag;
    logic signed [W-1:0] phase;

    modport master (
        output in_valid, x_in, y_in,
        input  busy, overrun, out_valid, mag, phase
    );

    modport slave (
        input  in_valid, x_in, y_in,
        output busy, overrun, out_valid, mag, phase
    );
endinterface

`default_nettype wire

// File: rtl/lockin_atan_rom.sv
// ============================================================================
// Module      : lockin_atan_rom
// Description : Combinational arctangent lookup, ATAN[i] scaled so that
//               2^(W-1) represents pi.
//   i_idx  : iteration index (CORDIC step counter)
//   o_atan : round(atan(2^-i)/pi * 2^(W-1))
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lockin_atan_rom
    import lockin_pkg::*;
#(
    parameter int W  = 32,
    parameter int CW = 5
) (
    input  logic [CW-1:0] i_idx,
    output logic [W-1:0]  o_atan
);

    logic [31:0] w_raw;

    assign w_raw = cordic_atan(int'(i_idx));

    generate
        if (W < 32) begin : g_narrow
            // Round to nearest while dropping the surplus fraction bits
            logic [32:0] w_sum;
            assign w_sum  = {1'b0, w_raw} + (33'd1 << (31 - W));
            assign o_atan = W'(w_sum >> (32 - W));
        end else if (W == 32) begin : g_exact
            assign o_atan = w_raw;
        end else begin : g_wide
            assign o_atan = W'(w_raw) << (W - 32);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/lockin_polar.sv
// ============================================================================
// Module      : lockin_polar
// Description : Iterative CORDIC vectoring stage: converts the filtered I/Q
//               pair into magnitude and phase, one conversion at a time.
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : in_valid/x_in/y_in in; busy, overrun, out_valid,
//                     mag (unsigned, saturating), phase (signed, 2^(W-1)=pi)
//   Build option    : LOCKIN_POLAR_GAINCOMP_EN adds a COMP state that scales
//                     mag by 1/An (true magnitude, one extra clock latency).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lockin_polar
    import lockin_pkg::*;
#(
    parameter int W    = 32,
    parameter int ITER = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    lockin_polar_if.slave bus
);

    // Two guard bits absorb -(-2^(W-1)) and the sqrt(2)*1.647 growth
    localparam int              C_XW      = W + 2;
    localparam int              C_CW      = $clog2(C_ITER_MAX + 1);
    localparam logic [C_CW-1:0] C_LAST    = C_CW'(ITER);
    localparam logic [W-1:0]    C_QUARTER = W'(1) << (W - 2);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_capture;
    logic                    w_fold;
    logic                    w_rotate;
    logic                    w_finish;

    logic [C_CW-1:0]         r_cnt;
    logic signed [C_XW-1:0]  r_x;
    logic signed [C_XW-1:0]  r_y;
    logic [W-1:0]            r_z;
    logic                    r_zero;

    logic                    r_out_valid;
    logic                    r_overrun;
    logic [W-1:0]            r_mag;
    logic [W-1:0]            r_phase;

    logic signed [C_XW-1:0]  w_x_sh;
    logic signed [C_XW-1:0]  w_y_sh;
    logic [W-1:0]            w_atan;
    logic [W-1:0]            w_mag_out;

    lockin_atan_rom #(
        .W  (W),
        .CW (C_CW)
    ) u_atan (
        .i_idx  (r_cnt),
        .o_atan (w_atan)
    );

    assign w_x_sh = r_x >>> r_cnt;
    assign w_y_sh = r_y >>> r_cnt;

`ifdef LOCKIN_POLAR_GAINCOMP_EN
    // Final x is non-negative, so an unsigned product is exact
    logic [C_XW+31:0] w_prod;
    assign w_prod    = (C_XW + 32)'($unsigned(r_x)) * (C_XW + 32)'(C_GAIN_K);
    assign w_mag_out = W'(w_prod >> 32);
`else
    // Raw CORDIC x; clamp when the gain pushes it beyond W bits
    assign w_mag_out = (r_x[C_XW-1:W] != 2'b00) ? '1 : r_x[W-1:0];
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and datapath strobes. ROT runs ITER rotation cycles plus
    // one closing cycle (counter == ITER) in which the result is handed
    // on, giving the ITER+2 clock latency.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_fold      = 1'b0;
        w_rotate    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_PRE;
                end
            end
            S_PRE: begin
                w_fold      = 1'b1;
                w_state_nxt = S_ROT;
            end
            S_ROT: begin
                if (r_cnt != C_LAST) begin
                    w_rotate = 1'b1;
                end else begin
`ifdef LOCKIN_POLAR_GAINCOMP_EN
                    w_state_nxt = S_COMP;
`else
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
`endif
                end
            end
`ifdef LOCKIN_POLAR_GAINCOMP_EN
            S_COMP: begin
                w_finish    = 1'b1;
                w_state_nxt = S_IDLE;
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_mag       <= '0;
            r_phase     <= '0;
        end else begin
            r_out_valid <= 1'b0;
            // A strobe while busy is dropped; only flag it
            r_overrun   <= bus.in_valid && (r_state != S_IDLE);

            if (w_capture) begin
                r_x <= {{2{bus.x_in[W-1]}}, bus.x_in};
                r_y <= {{2{bus.y_in[W-1]}}, bus.y_in};
            end

            // Quadrant fold into the right half-plane so the rotations only
            // need to cover +/- pi/2
            if (w_fold) begin
                r_cnt  <= '0;
                r_zero <= (r_x == '0) && (r_y == '0);
                if (!r_x[C_XW-1]) begin
                    r_z <= '0;
                end else if (!r_y[C_XW-1]) begin
                    r_x <= r_y;
                    r_y <= -r_x;
                    r_z <= C_QUARTER;
                end else begin
                    r_x <= -r_y;
                    r_y <= r_x;
                    r_z <= -C_QUARTER;
                end
            end

            if (w_rotate) begin
                r_cnt <= r_cnt + C_CW'(1);
                if (!r_y[C_XW-1]) begin
                    r_x <= r_x + w_y_sh;
                    r_y <= r_y - w_x_sh;
                    r_z <= r_z + w_atan;
                end else begin
                    r_x <= r_x - w_y_sh;
                    r_y <= r_y + w_x_sh;
                    r_z <= r_z - w_atan;
                end
            end

            if (w_finish) begin
                r_out_valid <= 1'b1;
                r_mag       <= w_mag_out;
                // The rotations always step z, so a zero vector would
                // otherwise report the sum of the table
                r_phase     <= r_zero ? '0 : r_z;
            end
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.overrun   = r_overrun;
    assign bus.out_valid = r_out_valid;
    assign bus.mag       = r_mag;
    assign bus.phase     = r_phase;

endmodule

`default_nettype wire
